// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] CPU_RESET_ADDR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// In-order instruction buffer between the ROM response port and decode.
// Flush wins over push and pop; the head entry reads as zero when empty.
module ifu_fetch_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: credit-limited ROM requests, in-order response
// buffering and jump redirect with drain of stale in-flight responses.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_ADDR,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] rom_addr_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic [31:0] rom_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic            jump;
    logic            issue;
    logic            accept;
    logic            rsp;
    logic            push;
    logic            pop;
    fetch_entry_t    head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Handshake decode and next state; credits cover in-flight plus buffered words.
    always_comb begin
        state_next = state;
        jump       = 1'b0;
        issue      = 1'b0;
        rsp        = 1'b0;
        push       = 1'b0;
        unique case (state)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN: begin
                jump  = jump_req_i;
                issue = !jump_req_i &&
                        ((SW'(outstanding) + SW'(fifo_count)) < SW'(DEPTH));
                rsp   = rsp_valid_i;
                push  = rsp_valid_i && !jump_req_i;
            end
            ST_DRAIN: begin
                jump = jump_req_i;
                rsp  = rsp_valid_i;
            end
            default: state_next = ST_IDLE;
        endcase
        accept           = issue && req_ready_i;
        outstanding_next = outstanding + CW'(accept) - CW'(rsp);
        pop              = !fifo_empty && inst_ready_i && !jump;
        if (state == ST_RUN && jump && outstanding_next != '0) state_next = ST_DRAIN;
        if (state == ST_DRAIN && outstanding_next == '0)       state_next = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            rsp_ready_o <= 1'b0;
        end else begin
            rsp_ready_o <= 1'b1;
            outstanding <= outstanding_next;
            if (jump) begin
                pc     <= word_align(jump_addr_i);
                rsp_pc <= word_align(jump_addr_i);
            end else begin
                if (accept) pc     <= pc + PC_STEP;
                if (push)   rsp_pc <= rsp_pc + PC_STEP;
            end
        end
    end

    ifu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (jump),
        .wdata ('{addr: rsp_pc, data: rom_data_i}),
        .rdata (head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rom_addr_o   = pc;
    assign req_valid_o  = issue;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = head.data;
    assign inst_addr_o  = head.addr;

    // In-flight requests can never outnumber the buffer slots reserved for them.
    assert property (@(posedge clk) disable iff (!rst_n) outstanding <= CW'(DEPTH));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: ROM and decode models plus a queue-level
// reference of fetch order, epoch-based drop of stale responses and buffering.
`timescale 1ns/1ps
module tb_ifu_fetch;
    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        jump_req, req_valid, req_ready, rsp_valid, rsp_ready;
    logic        inst_valid, inst_ready;
    logic [31:0] jump_addr, rom_addr, rom_data, inst, inst_addr;

    logic        w_jump_req, w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready;
    logic        w_inst_valid, w_inst_ready;
    logic [31:0] w_jump_addr, w_rom_addr, w_rom_data, w_inst_data, w_inst_addr;

    ifu_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .rom_addr_o(rom_addr), .req_valid_o(req_valid), .req_ready_i(req_ready),
        .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rom_data_i(rom_data),
        .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr),
        .inst_ready_i(inst_ready)
    );

    ifu_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(rst_n), .jump_req_i(w_jump_req), .jump_addr_i(w_jump_addr),
        .rom_addr_o(w_rom_addr), .req_valid_o(w_req_valid), .req_ready_i(w_req_ready),
        .rsp_valid_i(w_rsp_valid), .rsp_ready_o(w_rsp_ready), .rom_data_i(w_rom_data),
        .inst_valid_o(w_inst_valid), .inst_o(w_inst_data), .inst_addr_o(w_inst_addr),
        .inst_ready_i(w_inst_ready)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

    pend_t       pend[$];
    ent_t        fq[$];
    logic [31:0] acc_log[$], cons_log[$], w_acc[$], w_inst[$], w_data[$];
    logic [31:0] mpc, force_target, w_addr;
    int          epoch, cyc, coincide;
    bit          idle, force_jump, hold_rsp, w_has;
    int          p_ready, p_rsp, p_jump, p_inst, max_lat;
    int          tests, fails;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    function automatic logic [31:0] first_of(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fq.delete();
        mpc   = 32'h0000_0000;
        epoch = 0;
        idle  = 1'b1;
        w_has = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        bit          jmp, rspv, exp_req, acc;
        logic [31:0] tgt, rdat;
        int          stale;
        pend_t       h, p;
        ent_t        e;

        check("inst_valid", 32'(inst_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            check("inst_data", inst, fq[0].data);
            check("inst_addr", inst_addr, fq[0].addr);
        end else begin
            check("inst_data_empty", inst, 32'h0);
            check("inst_addr_empty", inst_addr, 32'h0);
        end
        check("rsp_ready", 32'(rsp_ready), 32'(!idle));

        jmp  = !idle && (force_jump || chance(p_jump));
        tgt  = force_jump ? force_target :
               (chance(25) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom());
        force_jump = 1'b0;
        rspv = !hold_rsp && pend.size() > 0 && pend[0].due <= cyc && chance(p_rsp);
        rdat = rspv ? rom_fn(pend[0].addr) : $urandom();
        if (rspv && jmp) coincide++;
        jump_addr   = tgt;
        jump_req    = jmp;
        rsp_valid   = rspv;
        rom_data    = rdat;
        req_ready   = chance(p_ready);
        inst_ready  = chance(p_inst);
        w_rsp_valid = w_has;
        w_rom_data  = w_has ? rom_fn(w_addr) : 32'h0;
        #1;

        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        exp_req = !idle && !jmp && stale == 0 && (pend.size() + fq.size()) < int'(DEPTH);
        check("req_valid", 32'(req_valid), 32'(exp_req));
        if (exp_req) check("rom_addr", rom_addr, mpc);
        acc = exp_req && req_ready;

        if (inst_ready && fq.size() > 0 && !jmp) begin
            e = fq.pop_front();
            cons_log.push_back(e.addr);
        end
        if (rspv) begin
            h = pend.pop_front();
            if (!jmp && h.epoch == epoch) begin
                e.addr = h.addr;
                e.data = rdat;
                fq.push_back(e);
            end
        end
        if (acc) begin
            p.addr  = mpc;
            p.epoch = epoch;
            p.due   = cyc + 1 + int'($urandom_range(max_lat - 1, 0));
            pend.push_back(p);
            acc_log.push_back(mpc);
            mpc += 32'd4;
        end
        if (jmp) begin
            epoch++;
            fq.delete();
            mpc = tgt & 32'hFFFF_FFFC;
        end

        w_has  = w_req_valid;
        w_addr = w_rom_addr;
        if (w_req_valid) w_acc.push_back(w_rom_addr);
        if (w_inst_valid) begin
            w_inst.push_back(w_inst_addr);
            w_data.push_back(w_inst_data);
        end

        idle = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        jump_req    = 1'b0;
        rsp_valid   = 1'b0;
        req_ready   = 1'b0;
        inst_ready  = 1'b0;
        w_rsp_valid = 1'b0;
        #1;
        check("rst_req_valid", 32'(req_valid), 32'h0);
        check("rst_rsp_ready", 32'(rsp_ready), 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_addr", inst_addr, 32'h0);
        check("rst_rom_addr", rom_addr, 32'h0);
        check("rst_w_rom_addr", w_rom_addr, WRAP_PC);
        check("rst_w_inst_valid", 32'(w_inst_valid), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; coincide = 0;
        force_jump = 1'b0; hold_rsp = 1'b0; force_target = 32'h0;
        jump_req = 1'b0; jump_addr = 32'h0; req_ready = 1'b0; rsp_valid = 1'b0;
        rom_data = 32'h0; inst_ready = 1'b0;
        w_jump_req = 1'b0; w_jump_addr = 32'h0; w_req_ready = 1'b1;
        w_rsp_valid = 1'b0; w_rom_data = 32'h0; w_inst_ready = 1'b1;
        p_ready = 100; p_rsp = 100; p_jump = 0; p_inst = 0; max_lat = 1;
        model_reset();
        @(negedge clk);

        // Decode stalled: only DEPTH words fetched, then issue stops.
        do_reset();
        acc_log.delete();
        run(12);
        check("stall_issue_count", 32'(acc_log.size()), 32'd2);
        check("stall_addr0", first_of(acc_log, 0), 32'h0);
        check("stall_addr1", first_of(acc_log, 1), 32'h4);
        check("wrap_fetch0", first_of(w_acc, 0), 32'hFFFF_FFF8);
        check("wrap_fetch1", first_of(w_acc, 1), 32'hFFFF_FFFC);
        check("wrap_fetch2", first_of(w_acc, 2), 32'h0000_0000);
        check("wrap_inst0", first_of(w_inst, 0), 32'hFFFF_FFF8);
        check("wrap_inst1", first_of(w_inst, 1), 32'hFFFF_FFFC);
        check("wrap_inst2", first_of(w_inst, 2), 32'h0000_0000);
        check("wrap_data0", first_of(w_data, 0), 32'h3F26_A5A5);

        p_inst = 100;
        acc_log.delete();
        run(6);
        check("resume_addr", first_of(acc_log, 0), 32'h8);

        // Jump with two requests in flight: both responses dropped.
        hold_rsp = 1'b1;
        run(4);
        check("two_outstanding", 32'(pend.size()), 32'd2);
        force_jump = 1'b1;
        force_target = 32'h100;
        acc_log.delete();
        cons_log.delete();
        run(1);
        hold_rsp = 1'b0;
        run(10);
        check("jump_fetch", first_of(acc_log, 0), 32'h100);
        check("jump_inst", first_of(cons_log, 0), 32'h100);

        // Unaligned target, jump in the same cycle as a response.
        hold_rsp = 1'b1;
        run(4);
        hold_rsp = 1'b0;
        force_jump = 1'b1;
        force_target = 32'h203;
        coincide = 0;
        acc_log.delete();
        cons_log.delete();
        run(12);
        check("jump_rsp_coincide", 32'(coincide), 32'd1);
        check("jump_align_fetch", first_of(acc_log, 0), 32'h200);
        check("jump_align_inst", first_of(cons_log, 0), 32'h200);

        // Reset with a full buffer and traffic in flight.
        p_inst = 0;
        run(8);
        check("full_before_reset", 32'(fq.size()), 32'd2);
        do_reset();
        p_inst = 100;
        acc_log.delete();
        w_acc.delete();
        run(6);
        check("restart_fetch", first_of(acc_log, 0), 32'h0);
        check("restart_wrap_fetch", first_of(w_acc, 0), WRAP_PC);

        // Randomized traffic segments.
        for (int seg = 0; seg < 15; seg++) begin
            p_ready = int'($urandom_range(100, 30));
            p_rsp   = int'($urandom_range(100, 30));
            p_inst  = int'($urandom_range(100, 20));
            p_jump  = int'($urandom_range(8, 0));
            max_lat = int'($urandom_range(4, 1));
            run(200);
            if (seg == 7) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
